// File: rtl/johnson_pkg.sv
// -----------------------------------------------------------------------------
// johnson_pkg
// Shared helpers for the parametrised Johnson (twisted-ring) counter.
//   jc_popcount  : number of set bits in a ring-width vector
//   jc_is_legal  : true when the n-bit ring has at most one adjacent-bit change
//   jc_index     : binary position 0..2n-1 of a legal ring state (0 if illegal)
//   JC_UP/JC_DN  : direction encodings for the dir input
// Vectors are passed zero-extended to JC_MAX_N bits together with the live
// width n, so one set of functions serves every ring width from 2 to 32.
// -----------------------------------------------------------------------------
package johnson_pkg;

  localparam int   JC_MAX_N = 32;
  localparam int   JC_IDX_W = 6;     // enough for 2*JC_MAX_N - 1 = 63
  localparam logic JC_UP    = 1'b0;  // shift toward MSB
  localparam logic JC_DN    = 1'b1;  // shift toward LSB

  function automatic int jc_popcount(input logic [JC_MAX_N-1:0] v);
    logic [JC_MAX_N-1:0] t;
    int                  cnt;
    t   = v;
    cnt = 0;
    for (int i = 0; i < JC_MAX_N; i++) begin
      cnt += int'(t[0]);
      t = t >> 1;
    end
    return cnt;
  endfunction

  // Adjacent-bit changes show up as ones in v ^ (v >> 1); only the lowest
  // n-1 positions compare two real ring bits.
  function automatic logic jc_is_legal(input logic [JC_MAX_N-1:0] v, input int n);
    logic [JC_MAX_N-1:0] mask;
    mask = (JC_MAX_N'(1) << (n - 1)) - JC_MAX_N'(1);
    return jc_popcount((v ^ (v >> 1)) & mask) <= 1;
  endfunction

  // Up count fills ones from the LSB, then drains them from the LSB once the
  // MSB is set, so the MSB selects which half of the cycle we are in.
  function automatic logic [JC_IDX_W-1:0] jc_index(input logic [JC_MAX_N-1:0] v, input int n);
    logic msb;
    int   pop;
    msb = |(v & (JC_MAX_N'(1) << (n - 1)));
    pop = jc_popcount(v);
    if (!jc_is_legal(v, n)) return '0;
    if (msb) return JC_IDX_W'(2 * n - pop);
    return JC_IDX_W'(pop);
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// -----------------------------------------------------------------------------
// johnson_decode
// Purely combinational decode of a Johnson ring state.
//   i_q      [N]  ring state
//   o_legal       state is one of the 2N legal patterns
//   o_idx    [IW] binary index 0..2N-1 (0 when illegal)
//   o_first       legal and at index 0        (down-count wrap point)
//   o_last        legal and at index 2N-1     (up-count wrap point)
// -----------------------------------------------------------------------------
module johnson_decode
  import johnson_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(2 * N)
) (
  input  logic [N-1:0]  i_q,
  output logic          o_legal,
  output logic [IW-1:0] o_idx,
  output logic          o_first,
  output logic          o_last
);

  logic [JC_MAX_N-1:0] w_q_ext;

  assign w_q_ext = JC_MAX_N'(i_q);
  assign o_legal = jc_is_legal(w_q_ext, N);
  assign o_idx   = IW'(jc_index(w_q_ext, N));
  assign o_first = o_legal && (o_idx == '0);
  assign o_last  = o_legal && (o_idx == IW'(2 * N - 1));

endmodule

// File: rtl/johnson_counter_param.sv
// -----------------------------------------------------------------------------
// johnson_counter_param
// N-bit Johnson counter (2N states) with parallel load, enable, up/down
// direction, illegal-state self-correction and index / terminal-count decode.
// N must lie in 2..32.
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   en            advance one state per clock
//   dir           0 = up (toward MSB), 1 = down (toward LSB)
//   load          synchronous parallel load (beats en/dir)
//   load_val [N]  pattern to load; illegal patterns load 0 and flag err
//   q        [N]  registered ring state
//   qb       [N]  ~q
//   idx      [IW] binary index of q, 0 when q is illegal
//   tc            next enabled step wraps the sequence
//   err           one-cycle pulse after an illegal state/load was rejected
// -----------------------------------------------------------------------------
module johnson_counter_param
  import johnson_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = $clog2(2 * N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          dir,
  input  logic          load,
  input  logic [N-1:0]  load_val,
  output logic [N-1:0]  q,
  output logic [N-1:0]  qb,
  output logic [IW-1:0] idx,
  output logic          tc,
  output logic          err
);

  logic [N-1:0] r_q;
  logic         r_err;
  logic [N-1:0] w_q_nxt;
  logic         w_err_nxt;
  logic         w_legal;
  logic         w_first;
  logic         w_last;
  logic         w_load_legal;

  johnson_decode #(.N(N)) u_decode (
    .i_q     (r_q),
    .o_legal (w_legal),
    .o_idx   (idx),
    .o_first (w_first),
    .o_last  (w_last)
  );

  assign w_load_legal = jc_is_legal(JC_MAX_N'(load_val), N);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    w_q_nxt   = r_q;
    w_err_nxt = 1'b0;
    if (load) begin
      w_q_nxt   = w_load_legal ? load_val : '0;
      w_err_nxt = !w_load_legal;
    end else if (!w_legal) begin
      // An upset ring would otherwise circulate its bad pattern forever.
      w_q_nxt   = '0;
      w_err_nxt = 1'b1;
    end else if (en) begin
      if (dir == JC_UP) w_q_nxt = {r_q[N-2:0], ~r_q[N-1]};
      else              w_q_nxt = {~r_q[0], r_q[N-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples pre-edge values.
    if (rst) begin
      r_q   <= '0;
      r_err <= 1'b0;
    end else begin
      r_q   <= w_q_nxt;
      r_err <= w_err_nxt;
    end
  end

  assign q   = r_q;
  assign qb  = ~r_q;
  assign err = r_err;
  // A load in progress or a corrupt ring means the next step is not a wrap.
  assign tc  = en && !load && w_legal && ((dir == JC_UP) ? w_last : w_first);

endmodule
